// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - producer, register-file write and decode-lookup bundle for regfile_wb_queue
// fwd_data1/fwd_data2 exist only when WB_FORWARD_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

interface regfile_wb_queue_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 4
);
  logic                      alu_valid;
  logic                      alu_ready;
  logic [4:0]                alu_addr;
  logic [DATA_WIDTH-1:0]     alu_data;
  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [4:0]                lsu_addr;
  logic [DATA_WIDTH-1:0]     lsu_data;
  logic                      wb_stall;
  logic [4:0]                w_addr;
  logic [DATA_WIDTH-1:0]     w_data;
  logic                      w_ena;
  logic [4:0]                r_addr1;
  logic [4:0]                r_addr2;
  logic                      r_pend1;
  logic                      r_pend2;
  logic [$clog2(DEPTH):0]    q_count;
`ifdef WB_FORWARD_EN
  logic [DATA_WIDTH-1:0]     fwd_data1;
  logic [DATA_WIDTH-1:0]     fwd_data2;
`endif

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output wb_stall, r_addr1, r_addr2,
    input  alu_ready, lsu_ready,
    input  w_addr, w_data, w_ena,
    input  r_pend1, r_pend2, q_count
`ifdef WB_FORWARD_EN
    , input fwd_data1, fwd_data2
`endif
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  wb_stall, r_addr1, r_addr2,
    output alu_ready, lsu_ready,
    output w_addr, w_data, w_ena,
    output r_pend1, r_pend2, q_count
`ifdef WB_FORWARD_EN
    , output fwd_data1, fwd_data2
`endif
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue (LSU over ALU) draining into the regfile write port
// Optional WB_FORWARD_EN adds youngest-match forwarding data for the two decode read ports.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module regfile_wb_queue #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [4:0]            addr_q [DEPTH];
  logic [4:0]            addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];

  logic                  not_full;
  logic                  empty;
  logic                  push_lsu;
  logic                  push_alu;
  logic                  push;
  logic                  pop;
  logic [4:0]            push_addr;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DEPTH-1:0]      live;
  logic                  pend1;
  logic                  pend2;

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_live
    logic [PW-1:0] off;
    assign off     = PW'(i) - head_q;
    assign live[i] = {1'b0, off} < count_q;
  end

  assign not_full  = count_q < CW'(DEPTH);
  assign empty     = count_q == '0;

  assign bus.lsu_ready = !rst && not_full;
  assign bus.alu_ready = !rst && not_full && !bus.lsu_valid;

  assign push_lsu  = bus.lsu_valid && bus.lsu_ready;
  assign push_alu  = bus.alu_valid && bus.alu_ready;
  assign push_addr = push_lsu ? bus.lsu_addr : bus.alu_addr;
  assign push_data = push_lsu ? bus.lsu_data : bus.alu_data;
  // Writes to x0 finish the handshake but never occupy a slot.
  assign push      = (push_lsu || push_alu) && (push_addr != 5'd0);

  // Reset also masks the write so a flush never leaks a stale entry into the regfile.
  assign pop       = !rst && !empty && !bus.wb_stall;
  assign bus.w_ena  = pop;
  assign bus.w_addr = empty ? 5'd0 : addr_q[head_q];
  assign bus.w_data = empty ? '0 : data_q[head_q];
  assign bus.q_count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && addr_q[i] == bus.r_addr1) pend1 = 1'b1;
      if (live[i] && addr_q[i] == bus.r_addr2) pend2 = 1'b1;
    end
  end

  assign bus.r_pend1 = pend1 && (bus.r_addr1 != 5'd0);
  assign bus.r_pend2 = pend2 && (bus.r_addr2 != 5'd0);

`ifdef WB_FORWARD_EN
  logic [PW-1:0]         ord_idx [DEPTH];
  logic [DATA_WIDTH-1:0] fwd1;
  logic [DATA_WIDTH-1:0] fwd2;

  for (genvar k = 0; k < DEPTH; k++) begin : g_ord
    assign ord_idx[k] = head_q + PW'(k);
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && addr_q[ord_idx[k]] == bus.r_addr1) fwd1 = data_q[ord_idx[k]];
      if (CW'(k) < count_q && addr_q[ord_idx[k]] == bus.r_addr2) fwd2 = data_q[ord_idx[k]];
    end
  end

  assign bus.fwd_data1 = fwd1;
  assign bus.fwd_data2 = fwd2;
`endif
endmodule
